// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one buart transmitter between NREQ producers.
// Define UART_ARB_LOCK_EN to let a requester keep the grant across bytes.
module uart_tx_arbiter #(
   parameter int NREQ = 4,
   parameter int GIDW = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_lock,
   output logic [NREQ-1:0]   req_ready,
   output logic [7:0]        uart_data,
   output logic              uart_wr,
   input  logic              uart_busy,
   output logic [GIDW-1:0]   grant_id,
   output logic              active,
   output logic [15:0]       tx_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SEND,
      S_GAP
   } state_t;

   state_t          state;
   state_t          state_d;
   logic [GIDW-1:0] winner;
   logic [GIDW-1:0] idx;
   logic            found;
   logic            accept;
   logic            lock_q;

   // Search starts just past the last grant so every source gets a turn.
   always_comb begin
      found  = 1'b0;
      winner = grant_id;
      idx    = grant_id;
      if (lock_q) begin
         found = req_valid[grant_id];
      end else begin
         for (int k = 1; k <= NREQ; k++) begin
            idx = GIDW'((int'(grant_id) + k) % NREQ);
            if (!found && req_valid[idx]) begin
               found  = 1'b1;
               winner = idx;
            end
         end
      end
   end

   always_comb begin
      state_d   = state;
      req_ready = '0;
      accept    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (found && !reset) begin
               accept            = 1'b1;
               req_ready[winner] = 1'b1;
               state_d           = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!uart_busy) state_d = S_SEND;
         end
         S_SEND:  state_d = S_GAP;
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uart_data <= 8'h00;
         uart_wr   <= 1'b0;
         grant_id  <= GIDW'(NREQ - 1);
         tx_count  <= 16'h0000;
      end else begin
         uart_wr <= (state == S_WAIT) && !uart_busy;
         if (accept) begin
            uart_data <= req_data[8*winner +: 8];
            grant_id  <= winner;
         end
         if (state == S_SEND) tx_count <= tx_count + 16'd1;
      end
   end

`ifdef UART_ARB_LOCK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       lock_q <= 1'b0;
      else if (accept) lock_q <= req_lock[winner];
   end
`else
   logic unused_lock;
   assign lock_q      = 1'b0;
   assign unused_lock = ^req_lock;
`endif

   assign active = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter.
// Lock expectations follow UART_ARB_LOCK_EN when defined.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_lock;
   logic [3:0]  req_ready;
   logic [7:0]  uart_data;
   logic        uart_wr;
   logic        uart_busy;
   logic [1:0]  grant_id;
   logic        active;
   logic [15:0] tx_count;

   int checks = 0;
   int errors = 0;

   uart_tx_arbiter #(.NREQ(4), .GIDW(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_lock  (req_lock),
      .req_ready (req_ready),
      .uart_data (uart_data),
      .uart_wr   (uart_wr),
      .uart_busy (uart_busy),
      .grant_id  (grant_id),
      .active    (active),
      .tx_count  (tx_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_lock  = '0;
      uart_busy = 1'b0;
      tick();
      tick();
      checks++;
      if ({uart_wr, uart_data, req_ready, active} !== 14'h0) begin
         errors++;
         $display("FAIL reset_outputs: got wr=%b data=%h rdy=%b act=%b want 0",
                  uart_wr, uart_data, req_ready, active);
      end
      checks++;
      if (grant_id !== 2'd3 || tx_count !== 16'h0) begin
         errors++;
         $display("FAIL reset_regs: got gid=%0d cnt=%h want gid=3 cnt=0000",
                  grant_id, tx_count);
      end
      reset = 1'b0;
   endtask

   task automatic test_single();
      req_valid = 4'b0001;
      req_data  = 32'h0000_0061;
      uart_busy = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL single_ready: got %b want 0001", req_ready);
      end
      tick();
      req_valid = '0;
      #1;
      checks++;
      if (req_ready !== 4'b0000 || active !== 1'b1 || uart_wr !== 1'b0) begin
         errors++;
         $display("FAIL single_wait: got rdy=%b act=%b wr=%b want 0000 1 0",
                  req_ready, active, uart_wr);
      end
      tick();
      checks++;
      if (uart_wr !== 1'b1 || uart_data !== 8'h61) begin
         errors++;
         $display("FAIL single_wr: got wr=%b data=%h want 1 61", uart_wr, uart_data);
      end
      tick();
      checks++;
      if (uart_wr !== 1'b0 || tx_count !== 16'd1 || uart_data !== 8'h61) begin
         errors++;
         $display("FAIL single_gap: got wr=%b cnt=%h data=%h want 0 0001 61",
                  uart_wr, tx_count, uart_data);
      end
      tick();
      checks++;
      if (active !== 1'b0) begin
         errors++;
         $display("FAIL single_idle: got act=%b want 0", active);
      end
   endtask

   task automatic test_fairness();
      logic [7:0] ed;
      int t;
      do_reset();
      req_valid = 4'b1111;
      req_data  = 32'hA3A2_A1A0;
      for (int n = 0; n < 5; n++) begin
         t = 0;
         while (uart_wr !== 1'b1 && t < 10) begin
            tick();
            t++;
         end
         ed = 8'hA0 + 8'(n % 4);
         checks++;
         if (uart_wr !== 1'b1 || uart_data !== ed || grant_id !== 2'(n % 4)) begin
            errors++;
            $display("FAIL fair_%0d: got wr=%b data=%h gid=%0d want 1 %h %0d",
                     n, uart_wr, uart_data, grant_id, ed, n % 4);
         end
         if (n == 4) req_valid = '0;
         tick();
      end
      tick();
      tick();
      checks++;
      if (active !== 1'b0 || tx_count !== 16'd5) begin
         errors++;
         $display("FAIL fair_end: got act=%b cnt=%0d want 0 5", active, tx_count);
      end
   endtask

   task automatic test_busy();
      logic ok;
      req_valid = 4'b0001;
      req_data  = 32'h0000_0055;
      uart_busy = 1'b1;
      tick();
      req_valid = '0;
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (uart_wr !== 1'b0 || active !== 1'b1) ok = 1'b0;
         tick();
      end
      checks++;
      if (!ok || uart_wr !== 1'b0) begin
         errors++;
         $display("FAIL busy_hold: got wr=%b act=%b want wr=0 act=1 throughout",
                  uart_wr, active);
      end
      uart_busy = 1'b0;
      tick();
      checks++;
      if (uart_wr !== 1'b1 || uart_data !== 8'h55 || active !== 1'b1) begin
         errors++;
         $display("FAIL busy_fire: got wr=%b data=%h act=%b want 1 55 1",
                  uart_wr, uart_data, active);
      end
      tick();
      checks++;
      if (uart_wr !== 1'b0) begin
         errors++;
         $display("FAIL busy_once: got wr=%b want 0", uart_wr);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      req_valid = 4'b0001;
      req_data  = 32'h0000_0033;
      uart_busy = 1'b1;
      tick();
      #2;
      reset     = 1'b1;
      req_valid = 4'b1001;
      req_data  = 32'h1300_0010;
      uart_busy = 1'b0;
      #1;
      checks++;
      if (uart_wr !== 1'b0 || req_ready !== 4'b0 || tx_count !== 16'h0 ||
          active !== 1'b0 || grant_id !== 2'd3) begin
         errors++;
         $display("FAIL midrst_async: got wr=%b rdy=%b cnt=%h act=%b gid=%0d want 0 0000 0000 0 3",
                  uart_wr, req_ready, tx_count, active, grant_id);
      end
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL midrst_ready: got %b want 0001", req_ready);
      end
      tick();
      req_valid = '0;
      tick();
      checks++;
      if (uart_wr !== 1'b1 || uart_data !== 8'h10 || grant_id !== 2'd0) begin
         errors++;
         $display("FAIL midrst_win: got wr=%b data=%h gid=%0d want 1 10 0",
                  uart_wr, uart_data, grant_id);
      end
      tick();
      tick();
   endtask

   task automatic test_lock();
`ifdef UART_ARB_LOCK_EN
      int nb = 5;
      logic [1:0] exp_g [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
`else
      int nb = 4;
      logic [1:0] exp_g [5] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd0};
`endif
      int n  = 0;
      int r1 = 0;
      logic [7:0] ed;
      do_reset();
      req_valid = 4'b0110;
      req_data  = 32'h0022_1100;
      req_lock  = 4'b0010;
      for (int c = 0; c < 80 && n < nb; c++) begin
         if (uart_wr === 1'b1) begin
            ed = (exp_g[n] == 2'd1) ? 8'h11 : 8'h22;
            checks++;
            if (grant_id !== exp_g[n] || uart_data !== ed) begin
               errors++;
               $display("FAIL lock_%0d: got gid=%0d data=%h want %0d %h",
                        n, grant_id, uart_data, exp_g[n], ed);
            end
            n++;
         end
         req_lock[1] = (r1 < 3);
         #1;
         if (req_ready[1] === 1'b1) r1++;
         tick();
      end
      req_valid = '0;
      req_lock  = '0;
      checks++;
      if (n != nb) begin
         errors++;
         $display("FAIL lock_count: got %0d bytes want %0d", n, nb);
      end
      tick();
      tick();
      tick();
   endtask

   task automatic test_wrap();
      req_valid = 4'b0001;
      req_data  = 32'h0000_0077;
      uart_busy = 1'b1;
      tick();
      req_valid = '0;
      force dut.tx_count = 16'hFFFF;
      #1;
      release dut.tx_count;
      uart_busy = 1'b0;
      tick();
      checks++;
      if (uart_wr !== 1'b1 || uart_data !== 8'h77) begin
         errors++;
         $display("FAIL wrap_wr: got wr=%b data=%h want 1 77", uart_wr, uart_data);
      end
      tick();
      checks++;
      if (tx_count !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_count: got %h want 0000", tx_count);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_busy();
      test_reset_mid();
      test_lock();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion want finish before 200000");
      $fatal(1);
   end

endmodule
